// File: rtl/hg_bell_arbiter.sv
// rtl/hg_bell_arbiter.sv - Halli Galli bell arbiter: sync, first-ring decision, grading, lockout.
// Optional HG_FALSE_START_EN: a bell edge while cards are not live is reported as a penalty.
module hg_bell_arbiter #(
  parameter int LOCK_CYCLES = 50,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic bell_1,
  input  logic bell_2,
  input  logic round_open,
  input  logic ring_correct,
  input  logic result_ack,
  output logic result_valid,
  output logic result_player,
  output logic result_win,
  output logic result_tie,
  output logic prio,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_REPORT,
    S_LOCK,
    S_RELEASE
  } state_t;

`ifdef HG_FALSE_START_EN
  localparam logic FALSE_START = 1'b1;
`else
  localparam logic FALSE_START = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'((LOCK_CYCLES > 0) ? LOCK_CYCLES - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       meta;
  logic [1:0]       sync;
  logic [1:0]       prev;
  logic [1:0]       rise;
  logic             take;
  logic             pick_player;
  logic             pick_win;
  logic             pick_tie;

  // Flops reset to "pressed" so a button held through reset never looks like a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 2'b11;
      sync <= 2'b11;
      prev <= 2'b11;
    end else begin
      meta <= {bell_2, bell_1};
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

  always_comb begin
    take        = 1'b0;
    pick_player = 1'b0;
    pick_win    = 1'b0;
    pick_tie    = 1'b0;
    if ((state == S_ARMED) || (FALSE_START && (state == S_IDLE))) begin
      take = |rise;
    end
    pick_tie    = &rise;
    pick_player = pick_tie ? prio : rise[1];
    pick_win    = (state == S_ARMED) && ring_correct;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      prio          <= 1'b0;
      result_valid  <= 1'b0;
      result_player <= 1'b0;
      result_win    <= 1'b0;
      result_tie    <= 1'b0;
      busy          <= 1'b0;
    end else if (take) begin
      state         <= S_REPORT;
      result_valid  <= 1'b1;
      result_player <= pick_player;
      result_win    <= pick_win;
      result_tie    <= pick_tie;
      prio          <= prio ^ pick_tie;
      busy          <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (round_open) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!round_open) begin
            state <= S_IDLE;
          end
        end
        S_REPORT: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            cnt          <= LOCK_LOAD;
            state        <= (LOCK_CYCLES == 0) ? S_RELEASE : S_LOCK;
          end
        end
        S_LOCK: begin
          if (cnt == '0) begin
            state <= S_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RELEASE: begin
          // Both buttons must be seen released before the bell can be rung again.
          if (sync == 2'b00) begin
            state <= round_open ? S_ARMED : S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hg_bell_arbiter.sv
// tb/tb_hg_bell_arbiter.sv - scoreboard bench for hg_bell_arbiter with a round-level reference model.
module tb_hg_bell_arbiter;

  localparam int LOCK = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bell_1 = 1'b0;
  logic bell_2 = 1'b0;
  logic round_open = 1'b0;
  logic ring_correct = 1'b0;
  logic result_ack = 1'b0;
  logic result_valid;
  logic result_player;
  logic result_win;
  logic result_tie;
  logic prio;
  logic busy;

  hg_bell_arbiter #(.LOCK_CYCLES(LOCK), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bell_1       (bell_1),
    .bell_2       (bell_2),
    .round_open   (round_open),
    .ring_correct (ring_correct),
    .result_ack   (result_ack),
    .result_valid (result_valid),
    .result_player(result_player),
    .result_win   (result_win),
    .result_tie   (result_tie),
    .prio         (prio),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit player;
    bit win;
    bit tie;
    bit prio;
    int at;
  } res_t;

  res_t res_q[$];
  int   vfall_q[$];
  int   bfall_q[$];
  bit   mprio = 1'b0;
  int   total = 0;
  int   bad = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents or retires a result.
  bit   pv = 1'b0;
  bit   pb = 1'b0;
  bit   have = 1'b0;
  res_t cur;
  always @(negedge clk) begin
    if (rst) begin
      pv   = 1'b0;
      pb   = 1'b0;
      have = 1'b0;
    end else begin
      if (result_valid && !pv) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          cur  = res_q.pop_front();
          have = 1'b1;
          chk("result_cycle", cyc, cur.at);
          chk("result_player", result_player, cur.player);
          chk("result_win", result_win, cur.win);
          chk("result_tie", result_tie, cur.tie);
          chk("prio_after", prio, cur.prio);
          chk("busy_with_result", busy, 1);
        end
      end else if (result_valid && have) begin
        chk("result_stable", {result_player, result_win, result_tie}, {cur.player, cur.win, cur.tie});
      end
      if (!result_valid && pv) begin
        have = 1'b0;
        if (vfall_q.size() == 0) chk("unexpected_valid_fall", 1, 0);
        else chk("valid_fall_cycle", cyc, vfall_q.pop_front());
      end
      if (!busy && pb) begin
        if (bfall_q.size() == 0) chk("unexpected_busy_fall", 1, 0);
        else chk("busy_fall_cycle", cyc, bfall_q.pop_front());
      end
      pv = result_valid;
      pb = busy;
    end
  end

  task automatic check_all_zero(string tag);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_player"}, result_player, 0);
    chk({tag, "_win"}, result_win, 0);
    chk({tag, "_tie"}, result_tie, 0);
    chk({tag, "_prio"}, prio, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // who: 1 = bell_1, 2 = bell_2, 3 = both in the same cycle.
  task automatic do_round(input int who, input bit rc, input bit hold2, input bit ro_drop, input int dly);
    int   n;
    int   a;
    int   bf;
    bit   held;
    res_t r;
    held = hold2 && (who >= 2);
    @(negedge clk);
    n = cyc;
    ring_correct = rc;
    bell_1 = (who != 2);
    bell_2 = (who >= 2);
    r.tie = (who == 3);
    r.player = (who == 3) ? mprio : (who == 2);
    r.win = rc;
    if (who == 3) mprio = ~mprio;
    r.prio = mprio;
    r.at = n + 3;
    res_q.push_back(r);
    repeat (2) @(negedge clk);
    if (ro_drop) round_open = 1'b0;
    @(negedge clk);
    bell_1 = 1'b0;
    if (!held) bell_2 = 1'b0;
    repeat (dly) @(negedge clk);
    a = cyc;
    result_ack = 1'b1;
    vfall_q.push_back(a + 1);
    bf = held ? a + LOCK + 13 : a + LOCK + 2;
    bfall_q.push_back(bf);
    @(negedge clk);
    result_ack = 1'b0;
    if (LOCK >= 8) bell_1 = 1'b1;
    @(negedge clk);
    bell_1 = 1'b0;
    if (held) begin
      while (cyc < a + LOCK + 10) @(negedge clk);
      bell_2 = 1'b0;
    end
    while (cyc < bf + 2) @(negedge clk);
    if (ro_drop) begin
      round_open = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic do_false_start();
    int   n;
    int   a;
    res_t r;
    @(negedge clk);
    round_open = 1'b0;
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    @(negedge clk);
    n = cyc;
    bell_1 = 1'b1;
`ifdef HG_FALSE_START_EN
    r.player = 1'b0;
    r.win = 1'b0;
    r.tie = 1'b0;
    r.prio = mprio;
    r.at = n + 3;
    res_q.push_back(r);
`endif
    repeat (2) @(negedge clk);
    bell_1 = 1'b0;
`ifdef HG_FALSE_START_EN
    repeat (3) @(negedge clk);
    a = cyc;
    result_ack = 1'b1;
    vfall_q.push_back(a + 1);
    bfall_q.push_back(a + LOCK + 2);
    @(negedge clk);
    result_ack = 1'b0;
    while (cyc < a + LOCK + 4) @(negedge clk);
`else
    a = n;
    repeat (10) @(negedge clk);
`endif
    round_open = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    res_t r;
    #1 rst = 1'b1;
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    round_open = 1'b1;
    repeat (3) @(negedge clk);

    do_round(1, 1'b1, 1'b0, 1'b0, 20);
    do_round(3, 1'b0, 1'b0, 1'b0, 3);
    do_round(3, 1'b0, 1'b0, 1'b0, 3);
    do_round(2, 1'b1, 1'b1, 1'b0, 2);
    do_round(1, 1'b1, 1'b0, 1'b1, 1);
    do_false_start();

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        do_false_start();
      end else begin
        do_round($urandom_range(1, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 20));
      end
    end

    // Asynchronous reset while a result is pending, with bell_1 held across release.
    @(negedge clk);
    n = cyc;
    ring_correct = 1'b1;
    bell_1 = 1'b1;
    r.player = 1'b0;
    r.win = 1'b1;
    r.tie = 1'b0;
    r.prio = mprio;
    r.at = n + 3;
    res_q.push_back(r);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    mprio = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("held_bell_no_result", result_valid, 0);
    bell_1 = 1'b0;
    repeat (5) @(negedge clk);

    chk("res_q_empty", res_q.size(), 0);
    chk("vfall_q_empty", vfall_q.size(), 0);
    chk("bfall_q_empty", bfall_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
